// File: rtl/memchk_pkg.sv
// Shared types, constants and the scratch-window compare for the store-sequence checker.
package memchk_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4
    } chkState_t;

    localparam int unsigned TOTAL_WR_W = 16;
    localparam int unsigned MAX_AW     = 64;

    // Window end is one bit wider than the address so base+size cannot wrap.
    function automatic logic inIgnWindow(
        input logic [MAX_AW-1:0] adr,
        input logic [MAX_AW-1:0] base,
        input logic [MAX_AW-1:0] size
    );
        logic [MAX_AW:0] winEnd;
        winEnd = {1'b0, base} + {1'b0, size};
        return (adr >= base) && ({1'b0, adr} < winEnd);
    endfunction

endpackage

// File: rtl/memchk_timer.sv
// RUN-phase cycle counter: saturates at TIMEOUT-1 and flags that terminal cycle.
module memchk_timer #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic lastCycle_c
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    assign lastCycle_c = (count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !lastCycle_c) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// In-order store-sequence checker with scratch-window filtering and a RUN timeout.
// Define MEMCHK_WRCOUNT_EN to build the saturating total_writes store counter.
module mem_write_checker
    import memchk_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned NUM_EXP  = 4,
    parameter int unsigned TIMEOUT  = 1000,
    parameter int unsigned IGN_BASE = 96,
    parameter int unsigned IGN_SIZE = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          MemWrite,
    input  logic [AW-1:0]                 DataAdr,
    input  logic [DW-1:0]                 WriteData,
    input  logic [NUM_EXP*AW-1:0]         exp_addr,
    input  logic [NUM_EXP*DW-1:0]         exp_data,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic                          fail,
    output logic                          timeout,
    output logic [$clog2(NUM_EXP+1)-1:0]  match_cnt,
    output logic [AW-1:0]                 fail_addr,
    output logic [DW-1:0]                 fail_data,
    output logic [TOTAL_WR_W-1:0]         total_writes
);

    localparam int unsigned MW = $clog2(NUM_EXP + 1);
    localparam int unsigned IW = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1;

    chkState_t     state;
    logic [IW-1:0] idx;
    logic [AW-1:0] curAddr;
    logic [DW-1:0] curData;
    logic          storeMatch;
    logic          storeIgnored;
    logic          lastCycle_c;

    // Select the expected entry currently being waited for.
    always_comb begin
        curAddr = '0;
        curData = '0;
        for (int i = 0; i < NUM_EXP; i++) begin
            if (idx == IW'(i)) begin
                curAddr = exp_addr[i*AW +: AW];
                curData = exp_data[i*DW +: DW];
            end
        end
    end

    assign storeMatch   = (DataAdr == curAddr) && (WriteData == curData);
    assign storeIgnored = inIgnWindow(MAX_AW'(DataAdr), MAX_AW'(IGN_BASE), MAX_AW'(IGN_SIZE));

    memchk_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .clear       (start),
        .enable      (state == S_RUN),
        .lastCycle_c (lastCycle_c)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            match_cnt <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
        end else if (start) begin
            state     <= S_RUN;
            idx       <= '0;
            match_cnt <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
        end else if (state == S_RUN) begin
            // A match beats the ignore window; a terminal store beats the timeout.
            if (MemWrite && storeMatch) begin
                match_cnt <= match_cnt + MW'(1);
                if (idx == IW'(NUM_EXP - 1)) begin
                    state <= S_PASS;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= 1'b1;
                end else begin
                    idx <= idx + IW'(1);
                    if (lastCycle_c) begin
                        state   <= S_TIMEOUT;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
            end else if (MemWrite && !storeIgnored) begin
                state     <= S_FAIL;
                busy      <= 1'b0;
                done      <= 1'b1;
                fail      <= 1'b1;
                fail_addr <= DataAdr;
                fail_data <= WriteData;
            end else if (lastCycle_c) begin
                state   <= S_TIMEOUT;
                busy    <= 1'b0;
                done    <= 1'b1;
                timeout <= 1'b1;
            end
        end
    end

`ifdef MEMCHK_WRCOUNT_EN
    logic [TOTAL_WR_W-1:0] wrCount;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wrCount <= '0;
        end else if (start) begin
            wrCount <= '0;
        end else if ((state == S_RUN) && MemWrite && (wrCount != '1)) begin
            wrCount <= wrCount + TOTAL_WR_W'(1);
        end
    end

    assign total_writes = wrCount;
`else
    assign total_writes = '0;
`endif

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: two configurations driven from one store bus and
// compared every cycle against an event-level reference model.
module tb_mem_write_checker;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned NE0 = 4;
    localparam int unsigned TO0 = 20;
    localparam int unsigned NE1 = 1;
    localparam int unsigned TO1 = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, MemWrite;
    logic [31:0]   DataAdr, WriteData;
    logic [31:0]   tA [NE0];
    logic [31:0]   tD [NE0];
    logic [NE0*AW-1:0] expA0;
    logic [NE0*DW-1:0] expD0;
    logic [AW-1:0] expA1;
    logic [DW-1:0] expD1;

    assign expA0 = {tA[3], tA[2], tA[1], tA[0]};
    assign expD0 = {tD[3], tD[2], tD[1], tD[0]};
    assign expA1 = 32'd100;
    assign expD1 = 32'd25;

    logic busy0, done0, pass0, fail0, tout0;
    logic [2:0]  mc0;
    logic [31:0] fa0, fd0;
    logic [15:0] tw0;
    logic busy1, done1, pass1, fail1, tout1;
    logic [0:0]  mc1;
    logic [31:0] fa1, fd1;
    logic [15:0] tw1;

    mem_write_checker #(.AW(AW), .DW(DW), .NUM_EXP(NE0), .TIMEOUT(TO0), .IGN_BASE(96), .IGN_SIZE(4)) dut0 (
        .clk(clk), .reset(reset), .start(start), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .exp_addr(expA0), .exp_data(expD0), .busy(busy0), .done(done0),
        .pass(pass0), .fail(fail0), .timeout(tout0), .match_cnt(mc0), .fail_addr(fa0),
        .fail_data(fd0), .total_writes(tw0));

    mem_write_checker #(.AW(AW), .DW(DW), .NUM_EXP(NE1), .TIMEOUT(TO1), .IGN_BASE(96), .IGN_SIZE(4)) dut1 (
        .clk(clk), .reset(reset), .start(start), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .exp_addr(expA1), .exp_data(expD1), .busy(busy1), .done(done1),
        .pass(pass1), .fail(fail1), .timeout(tout1), .match_cnt(mc1), .fail_addr(fa1),
        .fail_data(fd1), .total_writes(tw1));

    int total = 0;
    int bad   = 0;

    // Reference model: one record per configuration, advanced once per clock edge.
    bit          mRun [2], mPass [2], mFail [2], mTout [2];
    int          mMatch [2], mElap [2], mWr [2];
    logic [31:0] mFa [2], mFd [2];

    function automatic int numExp(input int k);
        return (k == 0) ? NE0 : NE1;
    endfunction

    function automatic int tmo(input int k);
        return (k == 0) ? TO0 : TO1;
    endfunction

    function automatic logic [31:0] expAddrOf(input int k, input int i);
        return (k == 0) ? tA[i] : 32'd100;
    endfunction

    function automatic logic [31:0] expDataOf(input int k, input int i);
        return (k == 0) ? tD[i] : 32'd25;
    endfunction

    function automatic void clearModel(input int k);
        mRun[k] = 0; mPass[k] = 0; mFail[k] = 0; mTout[k] = 0;
        mMatch[k] = 0; mElap[k] = 0; mWr[k] = 0; mFa[k] = '0; mFd[k] = '0;
    endfunction

    function automatic void modelEdge(input int k, input logic rs, input logic st, input logic we,
                                      input logic [31:0] a, input logic [31:0] d);
        if (!rs) begin
            clearModel(k);
            return;
        end
        if (st) begin
            clearModel(k);
            mRun[k] = 1;
            return;
        end
        if (!mRun[k]) return;
        if (we) begin
            if (mWr[k] < 65535) mWr[k]++;
            if (a == expAddrOf(k, mMatch[k]) && d == expDataOf(k, mMatch[k])) begin
                mMatch[k]++;
                if (mMatch[k] == numExp(k)) begin
                    mRun[k] = 0;
                    mPass[k] = 1;
                    return;
                end
            end else if (!(a >= 96 && a < 100)) begin
                mRun[k] = 0;
                mFail[k] = 1;
                mFa[k] = a;
                mFd[k] = d;
                return;
            end
        end
        mElap[k]++;
        if (mElap[k] == tmo(k)) begin
            mRun[k] = 0;
            mTout[k] = 1;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] twModel(input int k);
`ifdef MEMCHK_WRCOUNT_EN
        return 32'(mWr[k]);
`else
        return 32'(k - k);
`endif
    endfunction

    task automatic checkAll();
        chk("busy0",  32'(busy0), 32'(mRun[0]));
        chk("done0",  32'(done0), 32'(mPass[0] | mFail[0] | mTout[0]));
        chk("pass0",  32'(pass0), 32'(mPass[0]));
        chk("fail0",  32'(fail0), 32'(mFail[0]));
        chk("tout0",  32'(tout0), 32'(mTout[0]));
        chk("mcnt0",  32'(mc0),   32'(mMatch[0]));
        chk("faddr0", fa0,        mFa[0]);
        chk("fdata0", fd0,        mFd[0]);
        chk("twr0",   32'(tw0),   twModel(0));
        chk("busy1",  32'(busy1), 32'(mRun[1]));
        chk("done1",  32'(done1), 32'(mPass[1] | mFail[1] | mTout[1]));
        chk("pass1",  32'(pass1), 32'(mPass[1]));
        chk("fail1",  32'(fail1), 32'(mFail[1]));
        chk("tout1",  32'(tout1), 32'(mTout[1]));
        chk("mcnt1",  32'(mc1),   32'(mMatch[1]));
        chk("faddr1", fa1,        mFa[1]);
        chk("fdata1", fd1,        mFd[1]);
        chk("twr1",   32'(tw1),   twModel(1));
    endtask

    task automatic tick(input logic rs, input logic st, input logic we,
                        input logic [31:0] a, input logic [31:0] d);
        reset = rs; start = st; MemWrite = we; DataAdr = a; WriteData = d;
        @(posedge clk);
        modelEdge(0, rs, st, we, a, d);
        modelEdge(1, rs, st, we, a, d);
        #1;
        checkAll();
    endtask

    task automatic idle();
        tick(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        tick(1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic go();
        tick(1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] addrPick();
        case ($urandom_range(0, 7))
            0: return 32'd95;
            1: return 32'd96;
            2: return 32'd97;
            3: return 32'd99;
            4: return 32'd100;
            5: return 32'd101;
            6: return 32'd104;
            default: return 32'd108;
        endcase
    endfunction

    initial begin
        logic [31:0] twExp;
`ifdef MEMCHK_WRCOUNT_EN
        twExp = 32'd3;
`else
        twExp = 32'd0;
`endif
        tA[0] = 32'd100; tA[1] = 32'd104; tA[2] = 32'd108;        tA[3] = 32'd112;
        tD[0] = 32'd25;  tD[1] = 32'd3;   tD[2] = 32'hdeadbeef;   tD[3] = 32'd77;

        tick(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick(1'b0, 1'b1, 1'b1, 32'd100, 32'd25);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_mcnt", 32'(mc0), 32'd0);

        // Scratch stores then the single expected store.
        go();
        store(32'd96, 32'd7);
        store(32'd96, 32'd9);
        store(32'd100, 32'd25);
        chk("t1_pass", 32'(pass1), 32'd1);
        chk("t1_mcnt", 32'(mc1), 32'd1);
        chk("t1_fail", 32'(fail1), 32'd0);
        store(32'd104, 32'd3);
        store(32'd108, 32'hdeadbeef);
        store(32'd112, 32'd77);
        chk("seq_pass", 32'(pass0), 32'd1);
        chk("seq_mcnt", 32'(mc0), 32'd4);

        // Out-of-order store.
        go();
        store(32'd104, 32'd3);
        chk("t2_fail", 32'(fail0), 32'd1);
        chk("t2_faddr", fa0, 32'd104);
        chk("t2_fdata", fd0, 32'd3);
        chk("t2_mcnt", 32'(mc0), 32'd0);

        // Timeout after exactly TO0 RUN cycles, then sticky.
        go();
        repeat (19) idle();
        chk("t3_early", 32'(tout0), 32'd0);
        idle();
        chk("t3_tout", 32'(tout0), 32'd1);
        store(32'd100, 32'd25);
        chk("t3_sticky", 32'(tout0), 32'd1);
        chk("t3_nomatch", 32'(mc0), 32'd0);

        // Completing store on the timeout edge wins.
        go();
        repeat (4) idle();
        store(32'd100, 32'd25);
        chk("t4_pass", 32'(pass1), 32'd1);
        chk("t4_tout", 32'(tout1), 32'd0);

        // Reset mid-run, then a clean full sequence.
        go();
        store(32'd100, 32'd25);
        chk("t5_mid", 32'(mc0), 32'd1);
        tick(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("t5_rst", 32'(mc0), 32'd0);
        go();
        for (int i = 0; i < NE0; i++) store(tA[i], tD[i]);
        chk("t5_pass", 32'(pass0), 32'd1);

        // Store counting.
        go();
        store(32'd96, 32'd1);
        store(32'd96, 32'd2);
        store(32'd100, 32'd25);
        chk("t6_twr", 32'(tw0), twExp);

        // Expected entry inside the scratch window still counts as a match.
        tA[0] = 32'd97; tD[0] = 32'd5;
        go();
        store(32'd97, 32'd5);
        chk("prec_mcnt", 32'(mc0), 32'd1);
        chk("prec_fail", 32'(fail0), 32'd0);

        // Randomized runs.
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < NE0; i++) begin
                tA[i] = addrPick();
                tD[i] = 32'($urandom_range(0, 3));
            end
            go();
            for (int c = 0; c < 30; c++) begin
                int unsigned sel;
                sel = $urandom_range(0, 19);
                if (sel < 8 && mRun[0]) store(tA[mMatch[0]], tD[mMatch[0]]);
                else if (sel < 12) store(addrPick(), 32'($urandom_range(0, 3)));
                else if (sel == 12) tick(1'b1, 1'b1, 1'b1, addrPick(), 32'($urandom_range(0, 3)));
                else if (sel == 13 && $urandom_range(0, 3) == 0) tick(1'b0, 1'b0, 1'b1, 32'd100, 32'd25);
                else idle();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable store-sequence checker for the RISC-V pipeline top-level.
- Snoops the data-memory write port (MemWrite, DataAdr, WriteData) and matches stores, in order, against a parametrised table of NUM_EXP expected (address, data) pairs.
- Stores that fall in a scratch-address window are ignored.
- Reports PASS, FAIL or TIMEOUT through sticky status outputs. It replaces single-pair, single-scratch-address checking with an N-entry, timeout-bounded checker usable in simulation and on FPGA.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- NUM_EXP, 4, number of expected stores (>=1).
- TIMEOUT, 1000, cycles allowed in RUN before TIMEOUT (>=1).
- IGN_BASE, 96, first ignored (scratch) address.
- IGN_SIZE, 4, ignored window size in bytes; 0 disables ignoring.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; clears status and enters RUN.
- MemWrite  in  1  store strobe from the pipeline.
- DataAdr  in  AW  store address.
- WriteData  in  DW  store data.
- exp_addr  in  NUM_EXP*AW  expected addresses; entry i is at bits [i*AW +: AW].
- exp_data  in  NUM_EXP*DW  expected data, packed the same way.
- busy  out  1  high in RUN.
- done  out  1  high in PASS, FAIL or TIMEOUT.
- pass  out  1  high in PASS.
- fail  out  1  high in FAIL.
- timeout  out  1  high in TIMEOUT.
- match_cnt  out  $clog2(NUM_EXP+1)  number of expected stores matched so far.
- fail_addr  out  AW  address of the offending store.
- fail_data  out  DW  data of the offending store.
- total_writes  out  16  optional store counter (see Optional Feature).

Behaviour:
- Reset: when reset is low at a clk edge, go to IDLE. All outputs are 0, idx=0, cycle counter=0.
- States: IDLE, RUN, PASS, FAIL, TIMEOUT. Outputs are registered and decoded from state.
- IDLE: start goes to RUN.
- RUN, evaluated each clk edge in this priority order:
  1. A store with MemWrite=1, DataAdr==exp_addr[idx] and WriteData==exp_data[idx] is a match: idx++ and match_cnt++. If idx was NUM_EXP-1, go to PASS.
  2. A store with IGN_BASE <= DataAdr < IGN_BASE+IGN_SIZE is ignored. Unsigned compare, AW+1-bit sum so the window end does not wrap.
  3. Any other store goes to FAIL and captures fail_addr/fail_data.
  4. With no terminal event, if the cycle counter == TIMEOUT-1, go to TIMEOUT. Otherwise counter++.
- Store precedence: a store matching the expected entry counts as a match even if its address is inside the ignore window.
- Same-edge conflict: a PASS-completing store on the timeout edge gives PASS. A failing store on the timeout edge gives FAIL.
- PASS, FAIL and TIMEOUT are sticky until reset or start.
- start in any state, including mid-RUN, restarts: RUN, idx=0, counter=0, match_cnt=0, fail_addr/fail_data=0.
- A store on the same edge as start is not checked.
- Latency: a store on edge N is reflected in the outputs after edge N, so they are visible in the following cycle.
- X/Z on the store bus is not special-cased in RTL. In simulation an X compare falls to the FAIL path.
- The cycle counter is $clog2(TIMEOUT) bits wide and never wraps.

Optional Feature:
- Macro: MEMCHK_WRCOUNT_EN.
- Defined: total_writes counts every MemWrite=1 cycle in RUN (matched, ignored or failing), saturates at 16'hFFFF, and clears on reset or start.
- Undefined: total_writes is tied to 0 and its counter is not synthesized.

Decomposition:
- Package memchk_pkg holds:
  - the state enum (IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4, 3 bits);
  - the total_writes width constant (16);
  - an ignore-window compare function.
- One sub-module, memchk_timer: a cycle counter with a clear input, an enable input and a terminal flag at TIMEOUT-1.

Test Plan:
1. NUM_EXP=1, exp={100,25}. After start, stores (96,7), (96,9), (100,25): pass=1 one cycle after the third store, match_cnt=1, fail=0.
2. NUM_EXP=2, exp={(100,25),(104,3)}. Store (104,3) first: fail=1, fail_addr=104, fail_data=3, match_cnt=0.
3. TIMEOUT=20, no stores after start: timeout=1 after exactly 20 RUN cycles. Then a store (100,25): state unchanged.
4. TIMEOUT=5, NUM_EXP=1. Store (100,25) on the 5th RUN edge: pass=1, timeout=0.
5. Drop reset low mid-RUN with match_cnt=1: all outputs 0 next cycle. Then start and the full sequence: pass=1.
6. With MEMCHK_WRCOUNT_EN defined, stores (96,1), (96,2), (100,25): total_writes=3. With it undefined: total_writes=0.
